pio_edge_capture_in: RTL and testbench

- Parametrised Avalon-MM input PIO. Successor to the single-bit edge-capture input ports in nios_system.
- WIDTH independent input channels, each passed through a configurable synchroniser.
- Per-bit rising and/or falling edge capture with write-1-to-clear.
- Per-bit IRQ source select (level or captured edge); single registered irq to the Nios II interrupt controller.

---
 rtl/pio_edge_capture_pkg.sv | 14 +
 rtl/pio_in_channel.sv | 90 +++++++++
 rtl/pio_edge_capture_in.sv | 121 ++++++++++++
 tb/tb_pio_edge_capture_in.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pio_edge_capture_pkg.sv
// Shared definitions for the edge-capture input PIO.
// Register word addresses and the Avalon data width.
package pio_edge_capture_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_RISE_EN   = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK  = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP  = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN   = 3'd4;
    localparam logic [2:0] ADDR_LEVEL_SEL = 3'd5;

endpackage

// File: rtl/pio_in_channel.sv
// One input channel: synchroniser, optional debounce, edge detect.
// Ports: clk, reset_n (async low), in_bit -> f (filtered), rise, fall.
// Debounce filter is built only when PIO_DEBOUNCE_EN is defined.
module pio_in_channel #(
    parameter int   SYNC_STAGES     = 2,
    parameter logic RESET_VAL       = 1'b0,
    parameter int   DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_bit,
    output logic f,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;
    logic                   sync_out;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_bit};
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

`ifdef PIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             f_q;
    logic             f_d;

    // Counter runs only while the synchronised input disagrees with f;
    // any return to agreement restarts the stability window.
    always_comb begin
        f_d   = f_q;
        cnt_d = '0;
        if (sync_out != f_q) begin
            if (cnt_q == CNT_LAST) begin
                f_d = sync_out;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            f_q   <= RESET_VAL;
        end else begin
            cnt_q <= cnt_d;
            f_q   <= f_d;
        end
    end

    assign f = f_q;
`else
    assign f = sync_out;
`endif

    always_comb begin
        prev_d = f;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= RESET_VAL;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = f & ~prev_q;
    assign fall = ~f & prev_q;

endmodule

// File: rtl/pio_edge_capture_in.sv
// Avalon-MM input PIO with per-bit edge capture (W1C) and irq select.
// Ports: clk, reset_n, address/chipselect/write_n/writedata, in_port,
// readdata (1-clk latency), irq. Optional macro: PIO_DEBOUNCE_EN.
module pio_edge_capture_in
    import pio_edge_capture_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter int               SYNC_STAGES     = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0,
    parameter int               DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [DATA_W-1:0] readdata,
    output logic              irq
);

    logic [WIDTH-1:0] f_v;
    logic [WIDTH-1:0] rise_v;
    logic [WIDTH-1:0] fall_v;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        pio_in_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .RESET_VAL      (RESET_VALUE[i]),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk    (clk),
            .reset_n(reset_n),
            .in_bit (in_port[i]),
            .f      (f_v[i]),
            .rise   (rise_v[i]),
            .fall   (fall_v[i])
        );
    end

    logic [WIDTH-1:0]  rise_en_q,   rise_en_d;
    logic [WIDTH-1:0]  fall_en_q,   fall_en_d;
    logic [WIDTH-1:0]  irq_mask_q,  irq_mask_d;
    logic [WIDTH-1:0]  edge_cap_q,  edge_cap_d;
    logic [WIDTH-1:0]  level_sel_q, level_sel_d;
    logic [DATA_W-1:0] readdata_q,  readdata_d;
    logic              irq_q,       irq_d;

    logic              wr;
    logic [WIDTH-1:0]  wdata;
    logic [WIDTH-1:0]  set_v;
    logic [WIDTH-1:0]  clr_v;
    logic [WIDTH-1:0]  src_v;
    logic [WIDTH-1:0]  rd_sel;
    logic              unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    always_comb begin
        rise_en_d   = rise_en_q;
        fall_en_d   = fall_en_q;
        irq_mask_d  = irq_mask_q;
        level_sel_d = level_sel_q;
        clr_v       = '0;
        if (wr) begin
            case (address)
                ADDR_RISE_EN:   rise_en_d   = wdata;
                ADDR_FALL_EN:   fall_en_d   = wdata;
                ADDR_IRQ_MASK:  irq_mask_d  = wdata;
                ADDR_LEVEL_SEL: level_sel_d = wdata;
                ADDR_EDGE_CAP:  clr_v       = wdata;
                default:        clr_v       = '0;
            endcase
        end
        // A new edge overrides a same-cycle clear so no edge is lost.
        set_v      = (rise_v & rise_en_q) | (fall_v & fall_en_q);
        edge_cap_d = set_v | (edge_cap_q & ~clr_v);

        src_v = (level_sel_q & f_v) | (~level_sel_q & edge_cap_q);
        irq_d = |(src_v & irq_mask_q);

        // Read mux sees pre-write register state.
        case (address)
            ADDR_DATA:      rd_sel = f_v;
            ADDR_RISE_EN:   rd_sel = rise_en_q;
            ADDR_IRQ_MASK:  rd_sel = irq_mask_q;
            ADDR_EDGE_CAP:  rd_sel = edge_cap_q;
            ADDR_FALL_EN:   rd_sel = fall_en_q;
            ADDR_LEVEL_SEL: rd_sel = level_sel_q;
            default:        rd_sel = '0;
        endcase
        readdata_d = DATA_W'(rd_sel);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_en_q   <= '0;
            fall_en_q   <= '0;
            irq_mask_q  <= '0;
            edge_cap_q  <= '0;
            level_sel_q <= '0;
            readdata_q  <= '0;
            irq_q       <= 1'b0;
        end else begin
            rise_en_q   <= rise_en_d;
            fall_en_q   <= fall_en_d;
            irq_mask_q  <= irq_mask_d;
            edge_cap_q  <= edge_cap_d;
            level_sel_q <= level_sel_d;
            readdata_q  <= readdata_d;
            irq_q       <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_pio_edge_capture_in.sv
// Directed self-checking bench for pio_edge_capture_in.
// Read expectations go through a scoreboard queue.
module tb_pio_edge_capture_in;

    localparam int SYNC = 2;
`ifdef PIO_DEBOUNCE_EN
    localparam int DB = 16;
`else
    localparam int DB = 0;
`endif
    localparam int F_LAT = SYNC + DB;
    localparam int HOLD  = 10 + 2 * DB;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [7:0]  in_port = '0;
    logic [31:0] readdata;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    pio_edge_capture_in #(
        .WIDTH          (8),
        .SYNC_STAGES    (SYNC),
        .RESET_VALUE    (8'h00),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e,
                      input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        address = a;
        tick(1);
        check(tag_q.pop_front(), readdata, exp_q.pop_front());
    endtask

    initial begin
        #1;
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_rd", readdata, 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), 32'd0, $sformatf("rd_reset_a%0d", a));
        end
        check("idle_irq", {31'd0, irq}, 32'd0);

        // rising edge on bit 0, exact irq latency
        wr(3'd1, 32'h01);
        wr(3'd2, 32'h01);
        in_port[0] = 1'b1;
        tick(F_LAT + 1);
        check("irq_early", {31'd0, irq}, 32'd0);
        tick(1);
        check("irq_lat", {31'd0, irq}, 32'd1);
        rd(3'd3, 32'h01, "cap_b0");
        wr(3'd3, 32'h01);
        check("irq_hold", {31'd0, irq}, 32'd1);
        rd(3'd3, 32'h00, "cap_b0_clr");
        check("irq_clr", {31'd0, irq}, 32'd0);

        // both edges on bit 7
        in_port[7] = 1'b1;
        tick(HOLD);
        wr(3'd4, 32'h80);
        wr(3'd1, 32'h80);
        rd(3'd3, 32'h00, "cap_b7_none");
        in_port[7] = 1'b0;
        tick(HOLD);
        rd(3'd3, 32'h80, "cap_b7_fall");
        wr(3'd3, 32'h80);
        rd(3'd3, 32'h00, "cap_b7_clr");
        in_port[7] = 1'b1;
        tick(HOLD);
        rd(3'd3, 32'h80, "cap_b7_rise");
        wr(3'd3, 32'hFF);
        rd(3'd3, 32'h00, "cap_clr_all");

        // set beats same-cycle clear; W1C bit-selective
        wr(3'd1, 32'h06);
        in_port[1] = 1'b1;
        tick(HOLD);
        in_port[2] = 1'b1;
        tick(F_LAT);
        wr(3'd3, 32'h04);
        rd(3'd3, 32'h06, "cap_conflict");
        wr(3'd3, 32'h02);
        rd(3'd3, 32'h04, "cap_w1c_b1");
        wr(3'd3, 32'h04);
        rd(3'd3, 32'h00, "cap_w1c_b2");

        // level irq on bit 4
        wr(3'd5, 32'h10);
        wr(3'd2, 32'h10);
        rd(3'd5, 32'h10, "lvl_sel_rd");
        in_port[4] = 1'b1;
        tick(HOLD);
        check("irq_level_hi", {31'd0, irq}, 32'd1);
        wr(3'd3, 32'hFF);
        tick(2);
        check("irq_level_w1c", {31'd0, irq}, 32'd1);
        rd(3'd0, 32'h97, "data_97");
        in_port[4] = 1'b0;
        tick(HOLD);
        check("irq_level_lo", {31'd0, irq}, 32'd0);

        // ignored writes
        wr(3'd0, 32'hFFFF_FFFF);
        rd(3'd0, 32'h87, "data_ro");
        wr(3'd6, 32'hFFFF_FFFF);
        rd(3'd6, 32'h00, "rsvd6");
        wr(3'd1, 32'hFFFF_FF06);
        rd(3'd1, 32'h06, "rise_en_upper");

        // async reset mid-operation
        in_port[4] = 1'b1;
        tick(HOLD);
        check("irq_pre_rst", {31'd0, irq}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_rd", readdata, 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(HOLD);
        rd(3'd1, 32'h00, "rst_rise_en");
        rd(3'd3, 32'h00, "rst_cap");
        rd(3'd0, 32'h97, "rst_data");

`ifdef PIO_DEBOUNCE_EN
        wr(3'd1, 32'h08);
        in_port[3] = 1'b1;
        tick(10);
        in_port[3] = 1'b0;
        tick(40);
        rd(3'd0, 32'h97, "db_short_data");
        rd(3'd3, 32'h00, "db_short_cap");
        in_port[3] = 1'b1;
        tick(SYNC + 16);
        rd(3'd0, 32'h9F, "db_long_data");
        tick(1);
        in_port[3] = 1'b0;
        tick(40);
        rd(3'd3, 32'h08, "db_long_cap");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
